wb_ext_io_router: RTL and testbench
===================================

Name: wb_ext_io_router

Overview:
- Parametrised Wishbone (pipelined, stall-based) router for the SoC external-IO master port (word address, 32-bit data).
- Replaces fixed tie-offs of that port with NCH selectable slave channels, an unmapped-address default responder and a per-transaction timeout.
- Sits between the SoC core instance and external peripherals inside the top-level wrapper.
- One outstanding transaction at a time.

Parameters:
- ADR_W, 30, master/channel word-address width.
- NCH, 4, number of slave channels (1..2^CH_BITS).
- CH_BITS, 2, width of the channel-select field.
- CH_LSB, 20, LSB of the channel-select field in m_adr.
- TIMEOUT, 255, max cycles waiting for a channel ack (>=2).
- UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned for unmapped channels.
- TIMEOUT_DATA, 32'hFFFF_FFFF, read data returned on timeout.

Ports:
- ext_clk  in  1  system clock
- ext_rst  in  1  synchronous active-high reset
- m_adr  in  ADR_W  master word address
- m_dat_w  in  32  master write data
- m_sel  in  4  byte selects
- m_cyc  in  1  master cycle
- m_stb  in  1  master strobe
- m_we  in  1  write enable
- m_dat_r  out  32  read data, valid with m_ack
- m_ack  out  1  one-cycle acknowledge
- m_stall  out  1  router busy
- ch_cyc  out  NCH  per-channel cycle
- ch_stb  out  NCH  per-channel strobe
- ch_adr  out  ADR_W  shared latched address
- ch_dat_w  out  32  shared latched write data
- ch_sel  out  4  shared latched byte selects
- ch_we  out  1  shared latched write enable
- ch_dat_r  in  NCH*32  channel read data; channel i at [32*i+:32]
- ch_ack  in  NCH  channel acks
- ch_stall  in  NCH  channel stalls
- err_clr  in  1  clears sticky error flags
- err_timeout  out  1  sticky: a timeout occurred
- err_unmapped  out  1  sticky: an unmapped access occurred
- err_chan  out  CH_BITS  channel index of the most recent error

Behaviour:
- Reset: every output and internal register is 0. This includes m_stall, m_ack, ch_cyc, ch_stb, the error flags and err_chan. FSM goes to IDLE.
- Decode: idx = m_adr[CH_LSB +: CH_BITS]. The access is mapped iff idx < NCH.
- m_stall = 1 in every state except IDLE.
- IDLE:
  - A request is accepted on m_cyc & m_stb.
  - On accept, latch adr, dat_w, sel, we and idx, and clear the timeout counter.
  - Mapped request: go to ISSUE.
  - Unmapped request: go to RESP with m_dat_r = UNMAPPED_DATA (writes dropped), set err_unmapped, err_chan = idx.
- ISSUE:
  - ch_cyc[idx] = 1 and ch_stb[idx] = 1.
  - Stay in ISSUE while ch_stall[idx] = 1.
  - When ch_stall[idx] = 0, go to WAIT.
  - If ch_ack[idx] = 1 in the same cycle, go directly to RESP.
- WAIT:
  - ch_cyc[idx] = 1, ch_stb[idx] = 0.
  - On ch_ack[idx], capture ch_dat_r[idx] and go to RESP.
- RESP: m_ack = 1 for exactly one cycle with the captured m_dat_r, then go to IDLE. m_dat_r holds its value until the next response.
- Channel outputs: only ch_cyc/ch_stb[idx] ever assert. Every other channel bit stays 0 at all times.
- Latency, zero-stall channel that acks the cycle after its strobe:
  - T: request accepted.
  - T+1: ch_stb.
  - T+2: ch_ack.
  - T+3: m_ack.
- Latency, unmapped access: accept at T, m_ack at T+1.
- Timeout:
  - The counter increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT without an ack: drop ch_cyc/ch_stb, go to RESP with TIMEOUT_DATA, set err_timeout, err_chan = idx.
  - A late channel ack after that point is ignored.
  - If an ack and the timeout fall in the same cycle, the ack wins: real data is returned and no error is raised.
- Master abort: if m_cyc = 0 in ISSUE, WAIT or RESP, drop all ch_cyc/ch_stb the next cycle and return to IDLE. No m_ack is issued, no error is recorded, sticky flags are unchanged.
- Errors:
  - err_clr clears err_timeout and err_unmapped next cycle.
  - If an error event and err_clr coincide, the error event wins.
  - err_chan is not cleared by err_clr.
- ext_rst mid-transaction: all outputs return to reset values on the next edge; the pending transaction is discarded silently.
- ch_adr, ch_dat_w, ch_sel and ch_we hold the latched values until the next accept.

Test Plan:
- Read from channel 2 (m_adr = 30'h0020_0010, ch_dat_r[2] = 32'h1234_5678, ch_stall = 0, ack one cycle after strobe) -> ch_stb[2] at T+1, m_ack with m_dat_r = 32'h1234_5678 at T+3. m_stall = 1 from T+1 through T+3; other ch_cyc bits stay 0.
- Write to channel 0 with ch_stall[0] held high 3 cycles (m_dat_w = 32'hA5A5_0001, m_sel = 4'b0011) -> ch_stb[0] high for 4 cycles. ch_dat_w = 32'hA5A5_0001 and ch_sel = 4'b0011 throughout. Exactly one m_ack follows.
- NCH = 3, access with idx = 3 -> m_ack at T+1, m_dat_r = 32'hDEAD_BEEF, err_unmapped = 1, err_chan = 3, no ch_cyc asserted. err_clr pulse -> err_unmapped = 0 next cycle.
- TIMEOUT = 8, channel 1 never acks -> ch_cyc[1] drops after 8 cycles, m_ack with 32'hFFFF_FFFF, err_timeout = 1, err_chan = 1. A late ch_ack[1] produces no second m_ack.
- m_cyc dropped while in WAIT on channel 3 -> ch_cyc[3] = 0 next cycle, no m_ack, error flags unchanged. The next request is accepted normally.
- ext_rst asserted during ISSUE -> next edge all outputs 0, state IDLE. A subsequent read completes with standard T+3 latency.

Source files
------------

// File: rtl/wb_ext_io_router.sv
// wb_ext_io_router: routes the external-IO Wishbone master to NCH channels with unmapped responder and timeout
module wb_ext_io_router #(
  parameter int ADR_W = 30,
  parameter int NCH = 4,
  parameter int CH_BITS = 2,
  parameter int CH_LSB = 20,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic               ext_clk,
  input  logic               ext_rst,
  input  logic [ADR_W-1:0]   m_adr,
  input  logic [31:0]        m_dat_w,
  input  logic [3:0]         m_sel,
  input  logic               m_cyc,
  input  logic               m_stb,
  input  logic               m_we,
  output logic [31:0]        m_dat_r,
  output logic               m_ack,
  output logic               m_stall,
  output logic [NCH-1:0]     ch_cyc,
  output logic [NCH-1:0]     ch_stb,
  output logic [ADR_W-1:0]   ch_adr,
  output logic [31:0]        ch_dat_w,
  output logic [3:0]         ch_sel,
  output logic               ch_we,
  input  logic [NCH*32-1:0]  ch_dat_r,
  input  logic [NCH-1:0]     ch_ack,
  input  logic [NCH-1:0]     ch_stall,
  input  logic               err_clr,
  output logic               err_timeout,
  output logic               err_unmapped,
  output logic [CH_BITS-1:0] err_chan
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CH_BITS-1:0] idx, idx_r;
  logic [CW-1:0] cnt;
  logic mapped, acc, busy, ack, tmo, ack_ev, tmo_ev, unm_ev;
  assign idx = m_adr[CH_LSB +: CH_BITS];
  assign mapped = {1'b0, idx} < (CH_BITS + 1)'(NCH);
  assign acc = state == IDLE && m_cyc && m_stb;
  assign busy = state == ISSUE || state == WAIT;
  // an ack only counts once the strobe has actually been taken by the channel
  assign ack = ch_ack[idx_r] && (state == WAIT || !ch_stall[idx_r]);
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign ack_ev = busy && m_cyc && ack;
  assign tmo_ev = busy && m_cyc && !ack && tmo;
  assign unm_ev = acc && !mapped;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = acc ? (mapped ? ISSUE : RESP) : IDLE;
      ISSUE, WAIT: state_nx = !m_cyc ? IDLE : (ack || tmo) ? RESP
                              : (state == ISSUE && !ch_stall[idx_r]) ? WAIT : state;
      default:     state_nx = IDLE;
    endcase
  end
  always_comb begin
    m_stall = state != IDLE;
    m_ack = state == RESP && m_cyc;
    ch_cyc = '0;
    ch_stb = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_cyc[i] = busy && idx_r == CH_BITS'(i);
      ch_stb[i] = state == ISSUE && idx_r == CH_BITS'(i);
    end
  end
  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      state <= IDLE;
      idx_r <= '0;
      cnt <= '0;
      ch_adr <= '0;
      ch_dat_w <= '0;
      ch_sel <= '0;
      ch_we <= 1'b0;
      m_dat_r <= '0;
      err_timeout <= 1'b0;
      err_unmapped <= 1'b0;
      err_chan <= '0;
    end else begin
      state <= state_nx;
      cnt <= acc ? '0 : busy ? cnt + 1'b1 : cnt;
      if (acc) begin
        idx_r <= idx;
        ch_adr <= m_adr;
        ch_dat_w <= m_dat_w;
        ch_sel <= m_sel;
        ch_we <= m_we;
      end
      m_dat_r <= ack_ev ? ch_dat_r[32*idx_r +: 32] : tmo_ev ? TIMEOUT_DATA
                 : unm_ev ? UNMAPPED_DATA : m_dat_r;
      err_timeout <= tmo_ev || (err_timeout && !err_clr);
      err_unmapped <= unm_ev || (err_unmapped && !err_clr);
      err_chan <= tmo_ev ? idx_r : unm_ev ? idx : err_chan;
    end
  end
endmodule

// File: tb/tb_wb_ext_io_router.sv
// tb_wb_ext_io_router: transaction-level random and directed checks of the router
module tb_wb_ext_io_router;
  localparam int ADR_W = 30, NCH = 3, CH_BITS = 2, CH_LSB = 20, TIMEOUT = 8;
  logic clk = 0, rst = 1;
  logic [ADR_W-1:0] m_adr = '0, ch_adr;
  logic [31:0] m_dat_w = '0, m_dat_r, ch_dat_w;
  logic [3:0] m_sel = '0, ch_sel;
  logic m_cyc = 0, m_stb = 0, m_we = 0, m_ack, m_stall, ch_we, err_clr = 0;
  logic [NCH-1:0] ch_cyc, ch_stb, ch_ack = '0, ch_stall = '0;
  logic [NCH*32-1:0] ch_dat_r = '0;
  logic err_timeout, err_unmapped;
  logic [CH_BITS-1:0] err_chan;
  int n_tot = 0, n_bad = 0;
  logic e_tmo = 0, e_unm = 0;
  int e_chan = 0;
  logic [31:0] e_rd = '0;

  wb_ext_io_router #(.ADR_W(ADR_W), .NCH(NCH), .CH_BITS(CH_BITS), .CH_LSB(CH_LSB), .TIMEOUT(TIMEOUT)) dut (
    .ext_clk(clk), .ext_rst(rst), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cyc(m_cyc),
    .m_stb(m_stb), .m_we(m_we), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_stall(m_stall),
    .ch_cyc(ch_cyc), .ch_stb(ch_stb), .ch_adr(ch_adr), .ch_dat_w(ch_dat_w), .ch_sel(ch_sel),
    .ch_we(ch_we), .ch_dat_r(ch_dat_r), .ch_ack(ch_ack), .ch_stall(ch_stall), .err_clr(err_clr),
    .err_timeout(err_timeout), .err_unmapped(err_unmapped), .err_chan(err_chan));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags();
    chk("err_timeout", err_timeout, e_tmo);
    chk("err_unmapped", err_unmapped, e_unm);
    chk("err_chan", err_chan, e_chan);
  endtask

  // a = ack offset in cycles after the first strobe cycle (-1: never), ab = cycle m_cyc drops (-1: never)
  task automatic run_txn(input logic [ADR_W-1:0] adr, input logic we, input logic [31:0] dw,
                         input logic [3:0] sel, input int stall_n, input int a, input int ab,
                         input logic clr, input logic [31:0] rd);
    int id, resp, e, last;
    logic mapped, got;
    logic [NCH-1:0] oh, ec, es;
    logic [31:0] exp_rd;
    id = int'(adr[CH_LSB +: CH_BITS]);
    mapped = id < NCH;
    oh = '0;
    if (mapped) oh[id] = 1'b1;
    got = mapped && a >= 0 && a < TIMEOUT;
    e = !mapped ? 0 : got ? a + 1 : TIMEOUT;
    resp = e;
    exp_rd = !mapped ? 32'hDEAD_BEEF : got ? rd : 32'hFFFF_FFFF;
    if (ab > resp) ab = -1;
    last = (a + 1 > resp + 2) ? a + 1 : resp + 2;
    @(posedge clk); #1;
    m_cyc = 1; m_stb = 1; m_adr = adr; m_we = we; m_dat_w = dw; m_sel = sel; err_clr = clr;
    @(negedge clk);
    chk("idle_stall", m_stall, 0);
    if (clr) begin e_tmo = 0; e_unm = 0; end
    if (!mapped) begin e_unm = 1; e_chan = id; end
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      m_stb = 0; err_clr = 0;
      m_adr = ADR_W'($urandom); m_dat_w = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
      if (ab >= 0 && k >= ab) m_cyc = 0;
      ch_stall = NCH'($urandom);
      ch_ack = NCH'($urandom);
      for (int c = 0; c < NCH; c++) ch_dat_r[32*c +: 32] = $urandom;
      if (mapped) begin
        ch_stall[id] = k < stall_n;
        ch_ack[id] = k == a;
        ch_dat_r[32*id +: 32] = rd;
      end
      @(negedge clk);
      ec = ((ab < 0 || k <= ab) && k < e) ? oh : '0;
      es = ((ab < 0 || k <= ab) && k < e && k <= stall_n) ? oh : '0;
      chk("ch_cyc", ch_cyc, ec);
      chk("ch_stb", ch_stb, es);
      chk("m_ack", m_ack, (ab < 0 || k < ab) && k == resp);
      chk("m_stall", m_stall, (ab < 0 || k <= ab) && k <= resp);
      if (k == resp && (ab < 0 || k < ab)) chk("m_dat_r", m_dat_r, exp_rd);
    end
    if (mapped && !got && (ab < 0 || ab >= TIMEOUT)) begin e_tmo = 1; e_chan = id; end
    if (ab < 0) begin
      e_rd = exp_rd;
      chk("m_dat_r_hold", m_dat_r, e_rd);
    end
    chk_flags();
    chk("ch_adr", ch_adr, adr);
    chk("ch_dat_w", ch_dat_w, dw);
    chk("ch_sel", ch_sel, sel);
    chk("ch_we", ch_we, we);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    e_tmo = 0; e_unm = 0;
    @(negedge clk);
    chk_flags();
  endtask

  initial begin
    int id, stall_n, a, ab, mode;
    logic [ADR_W-1:0] adr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", m_stall, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_cyc", ch_cyc, 0);
    chk("rst_stb", ch_stb, 0);
    chk("rst_dat_r", m_dat_r, 0);
    chk_flags();
    #1 rst = 0;
    run_txn(30'h0020_0010, 0, 32'h0, 4'hF, 0, 1, -1, 0, 32'h1234_5678);
    run_txn(30'h0000_0040, 1, 32'hA5A5_0001, 4'b0011, 3, 4, -1, 0, 32'h0BAD_0BAD);
    run_txn(30'h0030_0000, 0, 32'h0, 4'hF, 0, 1, -1, 0, 32'h0);
    pulse_clr();
    run_txn(30'h0010_0004, 0, 32'h0, 4'hF, 0, TIMEOUT + 2, -1, 0, 32'h5555_AAAA);
    run_txn(30'h0020_0008, 0, 32'h0, 4'hF, 0, 5, 3, 0, 32'h7777_7777);
    run_txn(30'h0010_0000, 0, 32'h0, 4'hF, 2, TIMEOUT - 1, -1, 0, 32'hC0FF_EE00);
    run_txn(30'h0030_0100, 1, 32'h1, 4'h1, 0, -1, -1, 1, 32'h0);
    // reset during ISSUE discards the transaction
    @(posedge clk); #1;
    m_cyc = 1; m_stb = 1; m_adr = 30'h0010_0020;
    @(posedge clk); #1;
    m_stb = 0; rst = 1;
    @(negedge clk);
    chk("issue_cyc", ch_cyc, 3'b010);
    @(posedge clk); #1 rst = 0; m_cyc = 0;
    e_tmo = 0; e_unm = 0; e_chan = 0; e_rd = 0;
    @(negedge clk);
    chk("rst2_stall", m_stall, 0);
    chk("rst2_cyc", ch_cyc, 0);
    chk("rst2_stb", ch_stb, 0);
    chk("rst2_adr", ch_adr, 0);
    chk("rst2_dat_r", m_dat_r, 0);
    chk_flags();
    run_txn(30'h0020_0010, 0, 32'h0, 4'hF, 0, 1, -1, 0, 32'h8765_4321);
    for (int t = 0; t < 60; t++) begin
      id = $urandom_range(0, 3);
      adr = ADR_W'($urandom);
      adr[CH_LSB +: CH_BITS] = CH_BITS'(id);
      mode = $urandom_range(0, 5);
      stall_n = (mode == 5) ? $urandom_range(0, TIMEOUT + 2) : $urandom_range(0, 3);
      a = (mode <= 2) ? stall_n + $urandom_range(0, 3) : (mode == 3) ? TIMEOUT + $urandom_range(0, 2) : -1;
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT) : -1;
      run_txn(adr, 1'($urandom), $urandom, 4'($urandom), stall_n, a, ab, $urandom_range(0, 4) == 0, $urandom);
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
